// File: rtl/amba_apb_pkg.sv
// Shared types and defaults for the APB master: FSM state encoding,
// default bus widths and the registered response record.
package amba_apb_pkg;

    localparam int APB_ADDR_W    = 8;
    localparam int APB_DATA_W    = 8;
    // Widest data bus the response record can carry; narrower buses use the low bits.
    localparam int APB_RSP_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RDWAIT = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic [APB_RSP_MAX_W-1:0] rdata;
        logic                     err;
    } apb_rsp_t;

endpackage

// File: rtl/amba_apb_master.sv
// Single-outstanding APB master. A command is accepted in IDLE, driven
// through SETUP and ACCESS, optionally followed by RDWAIT when read data
// arrives one cycle after completion, and finished with a one-cycle
// response pulse. A stalled slave is aborted after TIMEOUT_CYCLES
// ACCESS cycles without pready.
module amba_apb_master
    import amba_apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int RDATA_LAT      = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              pclk,
    input  logic              presetn,
    // command side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response side
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB side
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    // Counter must hold values up to TIMEOUT_CYCLES-1 without wrapping.
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 2);
    localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    apb_state_t        state, state_d;
    apb_rsp_t          rsp_q, rsp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_d;
    logic              rsp_valid_d;
    logic              psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic              timeout_hit;

    // The current cycle is the last allowed ACCESS cycle and the slave is still not ready.
    assign timeout_hit = TMO_EN && !pready && (cnt_q == TMO_LAST);

    assign rsp_rdata = rsp_q.rdata[DATA_W-1:0];
    assign rsp_err   = rsp_q.err;

    // Upper response bits are unused when DATA_W is narrower than the record.
    logic unused_rsp_hi;
    assign unused_rsp_hi = ^rsp_q.rdata;

    // State register; reset drops any transfer in flight immediately.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, next registered outputs and timeout counter update.
    always_comb begin
        state_d     = state;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_d       = rsp_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite;
        paddr_d     = paddr;
        pwdata_d    = pwdata;

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end

            ST_SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (pready) begin
                    if (pwrite || (RDATA_LAT == 0)) begin
                        // Completion takes priority over a timeout landing on the same cycle.
                        rsp_d       = '0;
                        if (!pwrite) begin
                            rsp_d.rdata[DATA_W-1:0] = prdata;
                        end
                        rsp_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end else if (timeout_hit) begin
                    rsp_d       = '0;
                    rsp_d.err   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end

            ST_RDWAIT: begin
                // Slave presents registered read data during this cycle.
                rsp_d                   = '0;
                rsp_d.rdata[DATA_W-1:0] = prdata;
                rsp_valid_d             = 1'b1;
                state_d                 = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // Registered outputs, captured command and timeout counter.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            cnt_q     <= '0;
        end else begin
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_q     <= rsp_d;
            psel      <= psel_d;
            penable   <= penable_d;
            pwrite    <= pwrite_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_amba_apb_master.sv
// Bench for amba_apb_master: two instances (registered-read slave with
// RDATA_LAT=1, combinational-read slave with RDATA_LAT=0) against a
// transaction-level model of latency, ACCESS length, timeout and memory.
module tb_amba_apb_master;

    localparam int TMO = 15;

    logic            pclk;
    logic            presetn;
    logic [1:0]      cmd_valid, cmd_ready, cmd_write;
    logic [1:0]      rsp_valid, rsp_err;
    logic [1:0]      psel, penable, pwrite, pready;
    logic [1:0][7:0] cmd_addr, cmd_wdata, rsp_rdata, paddr, pwdata, prdata;

    int         wait_cfg [2];
    logic [7:0] model_mem [2][256];
    int         checks;
    int         errors;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit exceeded");
        $fatal(1);
    end

    for (genvar g = 0; g < 2; g++) begin : g_inst
        amba_apb_master #(
            .ADDR_W(8), .DATA_W(8), .RDATA_LAT((g == 0) ? 1 : 0), .TIMEOUT_CYCLES(TMO)
        ) dut (
            .pclk(pclk), .presetn(presetn),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write[g]),
            .cmd_addr(cmd_addr[g]), .cmd_wdata(cmd_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
            .psel(psel[g]), .penable(penable[g]), .pwrite(pwrite[g]),
            .paddr(paddr[g]), .pwdata(pwdata[g]), .pready(pready[g]), .prdata(prdata[g])
        );

        logic [7:0] mem [256];
        int         acc_cnt;

        // Slave: ready after wait_cfg ACCESS cycles; negative means never.
        assign pready[g] = psel[g] && penable[g] && (wait_cfg[g] >= 0) && (acc_cnt >= wait_cfg[g]);

        always @(posedge pclk or negedge presetn) begin
            if (!presetn) acc_cnt <= 0;
            else if (psel[g] && penable[g] && !pready[g]) acc_cnt <= acc_cnt + 1;
            else acc_cnt <= 0;
        end

        always @(posedge pclk) begin
            if (psel[g] && penable[g] && pready[g] && pwrite[g]) mem[paddr[g]] <= pwdata[g];
        end

        if (g == 0) begin : g_reg
            logic [7:0] prdata_reg;
            always @(posedge pclk) begin
                if (psel[g] && penable[g] && pready[g] && !pwrite[g]) prdata_reg <= mem[paddr[g]];
                else prdata_reg <= 8'($urandom);
            end
            assign prdata[g] = prdata_reg;
        end else begin : g_comb
            assign prdata[g] = pready[g] ? mem[paddr[g]] : ~mem[paddr[g]];
        end
    end

    task automatic do_txn(input int idx, input bit wr, input logic [7:0] addr,
                          input logic [7:0] data, input int waits, input string tag);
        bit         exp_err;
        int         n_exp, lat, k, n_setup, n_acc, n_gap, stab_bad;
        logic [7:0] exp_rd;
        exp_err  = (waits < 0) || (waits >= TMO);
        n_exp    = exp_err ? TMO : waits + 1;
        exp_rd   = (wr || exp_err) ? 8'h00 : model_mem[idx][addr];
        lat      = 2 + n_exp + ((!wr && !exp_err && idx == 0) ? 1 : 0);
        k = 0; n_setup = 0; n_acc = 0; n_gap = 0; stab_bad = 0;
        wait_cfg[idx] = waits;
        @(negedge pclk);
        cmd_valid[idx] = 1'b1; cmd_write[idx] = wr; cmd_addr[idx] = addr; cmd_wdata[idx] = data;
        for (int t = 0; t < 50; t++) begin
            if (cmd_ready[idx]) break;
            @(negedge pclk);
        end
        checks++;
        if (cmd_ready[idx] !== 1'b1) begin
            errors++;
            $display("FAIL %s[%0d] accept: cmd_ready=%b required 1", tag, idx, cmd_ready[idx]);
            cmd_valid[idx] = 1'b0;
            return;
        end
        @(posedge pclk);
        #1 cmd_valid[idx] = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge pclk);
            if (rsp_valid[idx]) begin k = c; break; end
            if (psel[idx] && !penable[idx]) n_setup++;
            else if (psel[idx] && penable[idx]) n_acc++;
            else n_gap++;
            if (psel[idx] && (paddr[idx] !== addr || pwrite[idx] !== wr || pwdata[idx] !== data))
                stab_bad++;
        end
        checks++;
        if (k != lat) begin
            errors++;
            $display("FAIL %s[%0d] latency: got %0d required %0d", tag, idx, k, lat);
            return;
        end
        checks++;
        if (n_setup != 1) begin errors++; $display("FAIL %s[%0d] setup_cycles: got %0d required 1", tag, idx, n_setup); end
        checks++;
        if (n_acc != n_exp) begin errors++; $display("FAIL %s[%0d] access_cycles: got %0d required %0d", tag, idx, n_acc, n_exp); end
        checks++;
        if (n_gap != lat - 2 - n_exp) begin errors++; $display("FAIL %s[%0d] rdwait_cycles: got %0d required %0d", tag, idx, n_gap, lat - 2 - n_exp); end
        checks++;
        if (rsp_err[idx] !== exp_err) begin errors++; $display("FAIL %s[%0d] rsp_err: got %b required %b", tag, idx, rsp_err[idx], exp_err); end
        checks++;
        if (rsp_rdata[idx] !== exp_rd) begin errors++; $display("FAIL %s[%0d] rsp_rdata: got %h required %h", tag, idx, rsp_rdata[idx], exp_rd); end
        checks++;
        if (cmd_ready[idx] !== 1'b1 || psel[idx] !== 1'b0) begin
            errors++; $display("FAIL %s[%0d] idle_after_rsp: cmd_ready=%b psel=%b required 1 0", tag, idx, cmd_ready[idx], psel[idx]);
        end
        checks++;
        if (paddr[idx] !== addr || stab_bad != 0) begin
            errors++; $display("FAIL %s[%0d] addr_stable: paddr=%h glitches=%0d required %h 0", tag, idx, paddr[idx], stab_bad, addr);
        end
        @(negedge pclk);
        checks++;
        if (rsp_valid[idx] !== 1'b0) begin errors++; $display("FAIL %s[%0d] rsp_pulse_width: rsp_valid=%b required 0", tag, idx, rsp_valid[idx]); end
        if (wr && !exp_err) model_mem[idx][addr] = data;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        cmd_valid = '0; cmd_write = '0; cmd_addr = '0; cmd_wdata = '0;
        wait_cfg[0] = 0; wait_cfg[1] = 0;
        repeat (3) @(negedge pclk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({cmd_ready[i], psel[i], penable[i], pwrite[i], rsp_valid[i], rsp_err[i],
                 paddr[i], pwdata[i], rsp_rdata[i]} !== 30'd0) begin
                errors++; $display("FAIL reset[%0d] outputs_zero: psel=%b cmd_ready=%b rsp_valid=%b required all 0",
                                   i, psel[i], cmd_ready[i], rsp_valid[i]);
            end
        end
        #1 presetn = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 2'b00) begin errors++; $display("FAIL reset cmd_ready_before_edge: got %b required 00", cmd_ready); end
        @(negedge pclk);
        checks++;
        if (cmd_ready !== 2'b11) begin errors++; $display("FAIL reset cmd_ready_first_edge: got %b required 11", cmd_ready); end
    endtask

    task automatic test_write_basic();
        do_txn(0, 1'b1, 8'h05, 8'hA5, 0, "write_basic");
        checks++;
        if (g_inst[0].mem[8'h05] !== 8'hA5) begin
            errors++; $display("FAIL write_basic slave_mem: got %h required a5", g_inst[0].mem[8'h05]);
        end
    endtask

    task automatic test_read_rdwait();
        do_txn(0, 1'b0, 8'h05, 8'h00, 0, "read_rdwait");
    endtask

    task automatic test_read_wait_lat0();
        do_txn(1, 1'b1, 8'h22, 8'h3C, 0, "lat0_prep");
        do_txn(1, 1'b0, 8'h22, 8'h00, 3, "lat0_wait3");
    endtask

    task automatic test_timeout();
        do_txn(0, 1'b0, 8'h05, 8'h00, -1, "timeout_stuck");
        do_txn(1, 1'b1, 8'h30, 8'h77, -1, "timeout_stuck_wr");
        do_txn(1, 1'b0, 8'h22, 8'h00, TMO - 1, "ready_at_limit");
        do_txn(0, 1'b1, 8'h06, 8'h11, TMO, "ready_after_limit");
    endtask

    task automatic init_mem();
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 8; a++)
                do_txn(i, 1'b1, 8'(a), 8'($urandom), 0, "init");
    endtask

    task automatic test_random();
        int  idx, w, r;
        bit  wr;
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 1);
            wr  = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 9);
            if (r < 6) w = r % 4;
            else if (r == 6) w = TMO - 1;
            else if (r == 7) w = TMO;
            else if (r == 8) w = -1;
            else w = 2;
            do_txn(idx, wr, 8'($urandom_range(0, 7)), 8'($urandom), w, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a [4];
        logic [7:0] d [4];
        int acc_cyc [4];
        int n_acc, n_rsp, n_setup, cur, inflight, stab_bad, err_bad;
        bit pend;
        n_acc = 0; n_rsp = 0; n_setup = 0; cur = 0; inflight = 0; stab_bad = 0; err_bad = 0; pend = 1'b0;
        for (int i = 0; i < 4; i++) begin a[i] = 8'h10 + 8'(i); d[i] = 8'($urandom); acc_cyc[i] = 0; end
        wait_cfg[0] = 0;
        @(negedge pclk);
        cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[0] = a[0]; cmd_wdata[0] = d[0];
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge pclk);
            if (pend) begin
                pend = 1'b0;
                cur++;
                if (cur < 4) begin cmd_addr[0] = a[cur]; cmd_wdata[0] = d[cur]; end
                else cmd_valid[0] = 1'b0;
            end
            if (rsp_valid[0]) begin n_rsp++; if (rsp_err[0] !== 1'b0) err_bad++; end
            if (psel[0] && !penable[0]) n_setup++;
            if (psel[0] && (paddr[0] !== a[inflight] || pwdata[0] !== d[inflight])) stab_bad++;
            if (cmd_valid[0] && cmd_ready[0]) begin
                if (n_acc < 4) acc_cyc[n_acc] = cyc;
                n_acc++;
                inflight = cur;
                pend = 1'b1;
            end
        end
        checks++;
        if (n_acc != 4) begin errors++; $display("FAIL b2b accepts: got %0d required 4", n_acc); end
        checks++;
        if (n_setup != 4) begin errors++; $display("FAIL b2b transfers: got %0d required 4", n_setup); end
        checks++;
        if (n_rsp != 4 || err_bad != 0) begin errors++; $display("FAIL b2b responses: got %0d (err %0d) required 4 (err 0)", n_rsp, err_bad); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
                errors++; $display("FAIL b2b spacing%0d: got %0d required 3", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        checks++;
        if (stab_bad != 0) begin errors++; $display("FAIL b2b addr_stable: got %0d glitches required 0", stab_bad); end
        for (int i = 0; i < 4; i++) model_mem[0][a[i]] = d[i];
        checks++;
        if (g_inst[0].mem[a[3]] !== d[3]) begin errors++; $display("FAIL b2b slave_mem: got %h required %h", g_inst[0].mem[a[3]], d[3]); end
    endtask

    task automatic test_reset_mid_access();
        int spur;
        spur = 0;
        wait_cfg[0] = -1;
        @(negedge pclk);
        cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0; cmd_addr[0] = 8'h03; cmd_wdata[0] = 8'h00;
        @(posedge pclk);
        #1 cmd_valid[0] = 1'b0;
        repeat (3) @(negedge pclk);
        checks++;
        if (!(psel[0] && penable[0])) begin errors++; $display("FAIL rst_mid in_access: psel=%b penable=%b required 1 1", psel[0], penable[0]); end
        #2 presetn = 1'b0;
        #1;
        checks++;
        if ({psel[0], penable[0], cmd_ready[0], rsp_valid[0], paddr[0]} !== 12'd0) begin
            errors++; $display("FAIL rst_mid async_clear: psel=%b penable=%b cmd_ready=%b paddr=%h required 0", psel[0], penable[0], cmd_ready[0], paddr[0]);
        end
        repeat (2) @(negedge pclk);
        #1 presetn = 1'b1;
        #1;
        checks++;
        if (cmd_ready[0] !== 1'b0) begin errors++; $display("FAIL rst_mid ready_before_edge: got %b required 0", cmd_ready[0]); end
        @(negedge pclk);
        checks++;
        if (cmd_ready[0] !== 1'b1) begin errors++; $display("FAIL rst_mid ready_after_edge: got %b required 1", cmd_ready[0]); end
        for (int c = 0; c < 20; c++) begin
            @(negedge pclk);
            if (rsp_valid[0] || psel[0]) spur++;
        end
        checks++;
        if (spur != 0) begin errors++; $display("FAIL rst_mid no_rsp: got %0d active cycles required 0", spur); end
        wait_cfg[0] = 0;
        do_txn(0, 1'b0, 8'h03, 8'h00, 1, "after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_basic();
        test_read_rdwait();
        test_read_wait_lat0();
        test_timeout();
        init_mem();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/amba_apb_master.md
AMBA_APB_MASTER -- requirements
Module: amba_apb_master

Interface
REQ-001 Parameter ADDR_W, default 8, APB address width.
REQ-002 Parameter DATA_W, default 8, APB data width.
REQ-003 Parameter RDATA_LAT, default 1, selects the prdata sample point (0 = ACCESS completion edge, 1 = one cycle after completion).
REQ-004 Parameter TIMEOUT_CYCLES, default 15, sets the ACCESS cycles without pready before abort (0 = disabled).
REQ-005 pclk  in  1  sole clock; all state updates on the rising edge.
REQ-006 presetn  in  1  reset, asynchronous assert, active-low.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  master can accept a command.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_W  target address.
REQ-011 cmd_wdata  in  DATA_W  write data.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-014 rsp_err  out  1  transfer aborted by timeout; qualified by rsp_valid.
REQ-015 psel, penable, pwrite  out  1 each  APB control.
REQ-016 paddr  out  ADDR_W  and  pwdata  out  DATA_W  APB address and write data.
REQ-017 pready  in  1  and  prdata  in  DATA_W  APB slave response.

Function
REQ-018 States: IDLE, SETUP, ACCESS, RDWAIT.
REQ-019 cmd_ready SHALL be a register that is 1 only while the state is IDLE.
REQ-020 IDLE + cmd_valid + cmd_ready -> capture cmd_*; drive pwrite/paddr/pwdata from the captured values; go to SETUP; cmd_ready 0 next cycle.
REQ-021 SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
REQ-022 ACCESS: psel=1, penable=1; stay until pready=1 or timeout.
REQ-023 ACCESS + pready + (write or RDATA_LAT=0) -> sample prdata on that edge (reads only); rsp_valid=1 next cycle; go to IDLE.
REQ-024 ACCESS + pready + read + RDATA_LAT=1 -> RDWAIT with psel=penable=0; sample prdata at the end of RDWAIT; rsp_valid next cycle; go to IDLE.
REQ-025 The timeout counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with pready=0.
REQ-026 When the counter reaches TIMEOUT_CYCLES (nonzero), the master SHALL deassert psel/penable next cycle, pulse rsp_valid with rsp_err=1 and rsp_rdata=0, and return to IDLE.
REQ-027 If pready=1 in the same cycle the limit is reached, the master SHALL treat the transfer as a normal completion with rsp_err=0.
REQ-028 paddr, pwrite and pwdata SHALL stay stable from SETUP through ACCESS and hold their last values while IDLE.
REQ-029 Minimum command-to-command spacing SHALL be 3 cycles for writes and 4 cycles for reads with RDATA_LAT=1.
REQ-030 rsp_valid SHALL be high for exactly one cycle per accepted command; the master has no response backpressure.
REQ-031 cmd_valid while cmd_ready=0 SHALL be ignored without being queued.

Reset
REQ-032 presetn=0 SHALL immediately force state IDLE, zero all outputs (cmd_ready included), and clear the counter and captured command.
REQ-033 Reset during SETUP/ACCESS/RDWAIT SHALL abandon the transfer with no rsp_valid afterwards.
REQ-034 cmd_ready SHALL rise on the first pclk edge after presetn deasserts.

Structure
REQ-035 Package amba_apb_pkg SHALL hold the state enum, default ADDR_W/DATA_W, and the response struct (rdata, err).
REQ-036 The block is a single module; the timeout counter stays inline, with no sub-module.

Verification
REQ-037 Write addr 0x05 data 0xA5, pready tied to psel&penable -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid 1 cycle later with rsp_err=0; slave mem[0x05]=0xA5.
REQ-038 Read 0x05 after REQ-037 with RDATA_LAT=1 and a registered-prdata slave -> RDWAIT visited; rsp_rdata=0xA5.
REQ-039 Read with pready held low 3 ACCESS cycles, RDATA_LAT=0, prdata=0x3C on the ready edge -> ACCESS lasts 4 cycles; rsp_rdata=0x3C, rsp_err=0.
REQ-040 pready stuck 0, TIMEOUT_CYCLES=15 -> exactly 15 ACCESS cycles; rsp_valid with rsp_err=1, rsp_rdata=0; IDLE next.
REQ-041 presetn pulsed low mid-ACCESS -> psel/penable drop asynchronously; no rsp_valid; cmd_ready=1 one edge after release.
REQ-042 cmd_valid held high for 4 back-to-back writes -> exactly 4 transfers at 3-cycle spacing; paddr stable across each SETUP/ACCESS pair.
